// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// One shared BCD decoder is time-shared across four digits. Each digit is lit
// for ON_CYC cycles and is followed by GUARD_CYC cycles with all anodes off.
// New display values pass through a one-entry pending register. They are
// committed only at frame boundaries, so a frame never shows a mix of old and
// new digits.
module seg_scan_ctrl #(
  parameter int unsigned ON_CYC    = 50000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic        lz_blank,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx
);

  // A 20-bit counter holds any reload value up to 2^20-1.
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned DATA_W = 4 * DIG_W;

  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [DIG_W-1:0] BCD_OFF    = 4'hF;
  localparam logic [3:0]       AN_OFF     = 4'b1111;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [1:0]          idx_nxt;
  logic [DATA_W-1:0]   disp_q, disp_nxt;
  logic [DATA_W-1:0]   pend_q, pend_nxt;
  logic                pend_full_q, pend_full_nxt;
  logic [3:0]          an_nxt;
  logic [DIG_W-1:0]    bcd_nxt;
  logic [DIG_W-1:0]    dig_sel;
  logic                xfer;
  logic                frame;
  logic                blank;

  // Next-state, pending/display update, and next values of the registered outputs.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    idx_nxt       = digit_idx;
    disp_nxt      = disp_q;
    pend_nxt      = pend_q;
    pend_full_nxt = pend_full_q;
    frame         = 1'b0;
    dig_sel       = '0;
    blank         = 1'b0;
    an_nxt        = AN_OFF;
    bcd_nxt       = BCD_OFF;
    xfer          = load_valid & load_ready;

    // Dwell timer: the state advances on the cycle after the counter reaches zero.
    if (cnt_q == '0) begin
      unique case (state_q)
        ST_ON: begin
          state_nxt = ST_GUARD;
          cnt_nxt   = GUARD_LOAD;
        end
        ST_GUARD: begin
          state_nxt = ST_ON;
          cnt_nxt   = ON_LOAD;
          idx_nxt   = digit_idx + 2'd1;
          frame     = (digit_idx == 2'd3);
        end
        default: begin
          state_nxt = ST_GUARD;
          cnt_nxt   = GUARD_LOAD;
        end
      endcase
    end else begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end

    // A commit needs a full pending register, and a transfer needs an empty one.
    // The two therefore never happen in the same cycle.
    if (frame && pend_full_q) begin
      disp_nxt      = pend_q;
      pend_full_nxt = 1'b0;
    end
    if (xfer) begin
      pend_nxt      = load_data;
      pend_full_nxt = 1'b1;
    end

    // Select the digit and apply leading-zero blanking to the upcoming display content.
    unique case (idx_nxt)
      2'd0: begin
        dig_sel = disp_nxt[3:0];
        blank   = 1'b0;
      end
      2'd1: begin
        dig_sel = disp_nxt[7:4];
        blank   = (disp_nxt[15:4] == 12'h000);
      end
      2'd2: begin
        dig_sel = disp_nxt[11:8];
        blank   = (disp_nxt[15:8] == 8'h00);
      end
      default: begin
        dig_sel = disp_nxt[15:12];
        blank   = (disp_nxt[15:12] == 4'h0);
      end
    endcase
    blank = blank & lz_blank;

    // Drive the anodes and BCD code for the upcoming state.
    if (state_nxt == ST_ON) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      bcd_nxt = blank ? BCD_OFF : dig_sel;
    end
  end

  // State, data, and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GUARD;
      cnt_q       <= GUARD_LOAD;
      digit_idx   <= 2'd3;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      an          <= AN_OFF;
      bcd_out     <= BCD_OFF;
      load_ready  <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      digit_idx   <= idx_nxt;
      disp_q      <= disp_nxt;
      pend_q      <= pend_nxt;
      pend_full_q <= pend_full_nxt;
      an          <= an_nxt;
      bcd_out     <= bcd_nxt;
      load_ready  <= ~pend_full_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with ON_CYC=4 and GUARD_CYC=2.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        lz_blank;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int total;
  int bad;

  seg_scan_ctrl #(.ON_CYC(4), .GUARD_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .lz_blank   (lz_blank),
    .bcd_out    (bcd_out),
    .an         (an),
    .digit_idx  (digit_idx)
  );

  // 10-time-unit clock; the bench drives and samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for the first lit cycle of digit k.
  task automatic wait_on(input int k);
    int n;
    n = 0;
    while (!(digit_idx == 2'(k) && an != 4'b1111) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_on_idx", 16'(digit_idx), 16'(k));
  endtask

  // Wait (bounded) until load_ready is high.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!load_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 16'(load_ready), 16'd1);
  endtask

  // Check that digit k is lit for four cycles showing val, then enters guard.
  task automatic chk_digit(input int k, input logic [3:0] val);
    logic [3:0] an_exp;
    an_exp = ~(4'b0001 << k);
    wait_on(k);
    for (int i = 0; i < 4; i++) begin
      chk("dig_an", 16'(an), 16'(an_exp));
      chk("dig_bcd", 16'(bcd_out), 16'(val));
      @(negedge clk);
    end
    chk("guard_an", 16'(an), 16'hF);
    chk("guard_bcd", 16'(bcd_out), 16'hF);
  endtask

  // Present a value and hold load_valid until it has been accepted.
  task automatic send(input logic [15:0] d);
    int n;
    load_valid = 1'b1;
    load_data  = d;
    n = 0;
    while (!load_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 16'(load_ready), 16'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    lz_blank   = 1'b0;
    step(3);
    rst = 1'b0;

    // Reset state and exact scan timing with no load.
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_bcd", 16'(bcd_out), 16'hF);
    chk("rst_idx", 16'(digit_idx), 16'd3);
    chk("rst_ready", 16'(load_ready), 16'd1);
    step(1);
    chk("t1_an", 16'(an), 16'hF);
    step(1);
    chk("t2_an", 16'(an), 16'hE);
    chk("t2_bcd", 16'(bcd_out), 16'h0);
    chk("t2_idx", 16'(digit_idx), 16'd0);
    step(3);
    chk("t5_an", 16'(an), 16'hE);
    step(1);
    chk("t6_an", 16'(an), 16'hF);
    chk("t6_bcd", 16'(bcd_out), 16'hF);
    chk("t6_idx", 16'(digit_idx), 16'd0);
    step(2);
    chk("t8_an", 16'(an), 16'hD);
    chk("t8_idx", 16'(digit_idx), 16'd1);
    step(17);
    chk("t25_an", 16'(an), 16'hF);
    chk("t25_idx", 16'(digit_idx), 16'd3);
    step(1);
    chk("t26_an", 16'(an), 16'hE);
    chk("t26_idx", 16'(digit_idx), 16'd0);

    // Load during digit 2: old value stays visible until the next frame.
    wait_on(2);
    send(16'h1234);
    chk("ld_ready_low", 16'(load_ready), 16'd0);
    chk("ld_old_bcd", 16'(bcd_out), 16'h0);
    chk_digit(3, 4'h0);
    chk("pre_commit_ready", 16'(load_ready), 16'd0);
    wait_ready();
    chk("commit_an", 16'(an), 16'hE);
    chk_digit(0, 4'h4);
    chk_digit(1, 4'h3);
    chk_digit(2, 4'h2);
    chk_digit(3, 4'h1);

    // Leading-zero blanking on 0050, then the same value with blanking off.
    lz_blank = 1'b1;
    send(16'h0050);
    wait_ready();
    chk_digit(0, 4'h0);
    chk_digit(1, 4'h5);
    chk_digit(2, 4'hF);
    chk_digit(3, 4'hF);
    lz_blank = 1'b0;
    chk_digit(0, 4'h0);
    chk_digit(1, 4'h5);
    chk_digit(2, 4'h0);
    chk_digit(3, 4'h0);

    // All-zero value with blanking enabled: only digit 0 shows a code.
    lz_blank = 1'b1;
    send(16'h0000);
    wait_ready();
    chk_digit(0, 4'h0);
    chk_digit(1, 4'hF);
    chk_digit(2, 4'hF);
    chk_digit(3, 4'hF);

    // Back-pressure: ABCD is held until ready returns, then shown one frame later.
    send(16'h1111);
    chk("bp_ready_low", 16'(load_ready), 16'd0);
    send(16'hABCD);
    chk("bp_ready_low2", 16'(load_ready), 16'd0);
    chk("bp_first_bcd", 16'(bcd_out), 16'h1);
    chk_digit(1, 4'h1);
    chk_digit(2, 4'h1);
    chk_digit(3, 4'h1);
    wait_ready();
    chk_digit(0, 4'hD);
    chk_digit(1, 4'hC);
    chk_digit(2, 4'hB);
    chk_digit(3, 4'hA);

    // Reset while digit 1 is lit and the pending register is full.
    lz_blank = 1'b0;
    wait_on(1);
    send(16'h5678);
    chk("pr_ready_low", 16'(load_ready), 16'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rr_an", 16'(an), 16'hF);
    chk("rr_bcd", 16'(bcd_out), 16'hF);
    chk("rr_idx", 16'(digit_idx), 16'd3);
    chk("rr_ready", 16'(load_ready), 16'd1);
    step(1);
    chk("rr_t1_an", 16'(an), 16'hF);
    step(1);
    chk("rr_t2_an", 16'(an), 16'hE);
    chk_digit(0, 4'h0);
    chk_digit(1, 4'h0);
    chk_digit(2, 4'h0);
    chk_digit(3, 4'h0);
    chk_digit(0, 4'h0);
    chk_digit(1, 4'h0);
    chk("rr_ready_end", 16'(load_ready), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ON_CYC, default 50000, meaning clock cycles each digit stays lit (legal range 1..2^20).
REQ-002 The block SHALL have parameter GUARD_CYC, default 16, meaning all-anodes-off cycles between digits (legal range 1..2^20).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port load_valid, input, 1, asserted when load_data holds a new 4-digit value.
REQ-006 Port load_ready, output, 1, high when the pending register can accept a value.
REQ-007 Port load_data, input, 16, four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 Port lz_blank, input, 1, leading-zero blanking enable, sampled every cycle.
REQ-009 Port bcd_out, output, 4, code driven to the shared BCD-to-seven-segment decoder; 4'hF yields all segments off.
REQ-010 Port an, output, 4, active-low digit anode enables; an[i] selects digit i.
REQ-011 Port digit_idx, output, 2, index of the digit currently scanned.

Function
REQ-012 The block SHALL time-share one decoder across four digits using FSM states ON and GUARD.
REQ-013 A down-counter SHALL set state duration; on entry to ON it loads ON_CYC-1, on entry to GUARD it loads GUARD_CYC-1; state changes in the cycle after the counter reads 0.
REQ-014 ON->GUARD SHALL keep digit_idx; GUARD->ON SHALL increment digit_idx modulo 4 (3 wraps to 0).
REQ-015 In ON: an = all ones except an[digit_idx]=0; bcd_out = selected display digit, or 4'hF if that digit is blanked.
REQ-016 In GUARD: an = 4'b1111 and bcd_out = 4'hF.
REQ-017 Outputs an, bcd_out, digit_idx SHALL be registered (no combinational path from inputs).
REQ-018 Digit values >9 SHALL be forwarded unchanged to bcd_out; no range check.
REQ-019 With lz_blank=1, digit k (k=3,2,1) SHALL be blanked when it and all higher digits are zero; digit 0 is never blanked; with lz_blank=0 nothing is blanked.
REQ-020 A transfer occurs in a cycle where load_valid and load_ready are both 1; load_data is then captured into a one-entry pending register, which becomes full.
REQ-021 load_ready SHALL equal NOT pending-full, registered.
REQ-022 Frame boundary = the GUARD->ON transition into digit_idx 0; at each frame boundary a full pending register SHALL be copied to the display register and emptied.
REQ-023 Display register SHALL change only at frame boundaries (no tearing within a frame).
REQ-024 Transfer and frame boundary in the same cycle with pending empty: data captured to pending, committed at the next frame boundary.
REQ-025 Frame boundary with pending full: commit occurs, load_ready rises the following cycle; no transfer is possible in the commit cycle.
REQ-026 Latency from transfer to visible digit 0 SHALL be at most one frame = 4*(ON_CYC+GUARD_CYC) cycles plus 1.

Reset
REQ-027 While rst=1 at a clock edge: state=GUARD, counter=GUARD_CYC-1, digit_idx=3, display register=16'h0000, pending empty.
REQ-028 Outputs after reset: an=4'b1111, bcd_out=4'hF, digit_idx=3, load_ready=1.
REQ-029 rst asserted mid-ON or mid-load SHALL discard pending data and restart scanning; first lit digit after reset is digit 0 after GUARD_CYC cycles.

Verification (ON_CYC=4, GUARD_CYC=2)
REQ-030 Reset release, no load -> an=1111 for 2 cycles, then an=1110, bcd_out=0 for 4 cycles, then 2 guard cycles, then an=1101; full cycle repeats every 24 cycles.
REQ-031 Load 16'h1234 during digit 2 ON -> load_ready low next cycle; digits keep old value until next digit-0 entry; then bcd_out sequence 4,3,2,1 on an 1110,1101,1011,0111; load_ready high one cycle after commit.
REQ-032 lz_blank=1, load 16'h0050 -> digit 3 bcd_out=F, digit 2 bcd_out=F, digit 1 bcd_out=5, digit 0 bcd_out=0; lz_blank=0 -> digits show 0,0,5,0.
REQ-033 Load 16'h0000 with lz_blank=1 -> only digit 0 shows 0; digits 1-3 bcd_out=F with anode still active.
REQ-034 Second load_valid held while pending full -> not accepted until ready returns; value accepted then appears one frame later; value 16'hABCD passes A,B,C,D unchanged to bcd_out.
REQ-035 rst pulse during digit 1 ON with pending full -> an=1111, load_ready=1, display reads 0 on resume; pending value never shown.
